// File: rtl/minisrc_pkg.sv
// rtl/minisrc_pkg.sv - ALU opcodes, opcode decode helpers and sequencer FSM states
package minisrc_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_WB,
        ST_RESP
    } seq_state_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    // Ops whose 64-bit Z result is committed to the architectural HI/LO pair.
    function automatic logic is_wide_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg32.sv
// rtl/reg32.sv - enable-loaded register with synchronous active-high clear
//
// Ports:
//   clock  - rising-edge clock
//   clear  - synchronous active-high clear to zero (wins over enable)
//   enable - load d on the next rising edge
//   d / q  - data in / registered data out
module reg32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (enable) begin
            val_d = d;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives one ALU operation per request and returns its result
//
// Ports:
//   clock, clear                 - rising-edge clock, synchronous active-high reset
//   req_valid/req_ready          - request handshake; ready only while idle
//   req_op, req_a, req_b         - ALU instruction code, operand for Y, operand for B
//   alu_instruction/Y_in/B_in    - registered drive of the external combinational ALU
//   alu_Z_hi, alu_Z_lo           - ALU result halves
//   resp_valid/resp_ready        - response handshake; response held until accepted
//   resp_result/wide/err         - Z_lo of the op, HI/LO-writing op flag, error flag
//   hi_out, lo_out               - architectural HI and LO registers
module alu_op_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int OP_WIDTH     = 5,
    parameter int CHK_DIV_ZERO = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_WIDTH-1:0]   req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic [OP_WIDTH-1:0]   alu_instruction,
    output logic [DATA_WIDTH-1:0] alu_Y_in,
    output logic [DATA_WIDTH-1:0] alu_B_in,
    input  logic [DATA_WIDTH-1:0] alu_Z_hi,
    input  logic [DATA_WIDTH-1:0] alu_Z_lo,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_wide,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    import minisrc_pkg::*;

    seq_state_e            state_q, state_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [OP_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  wide_q, wide_d;
    logic                  err_q, err_d;

    logic                  y_en, b_en, z_en, hilo_en;
    logic [DATA_WIDTH-1:0] y_q, b_q, z_hi_q, z_lo_q;
    logic                  div_zero;

    // A zero divisor is known from the B register long before WB, so the
    // HI/LO commit can be suppressed without looking at the ALU output.
    assign div_zero = (CHK_DIV_ZERO != 0) && (op_q == OP_DIV) && (b_q == '0);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        instr_d  = instr_q;
        result_d = result_q;
        wide_d   = wide_q;
        err_d    = err_q;
        y_en     = 1'b0;
        b_en     = 1'b0;
        z_en     = 1'b0;
        hilo_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    if (is_legal_op(req_op)) begin
                        y_en    = 1'b1;
                        b_en    = 1'b1;
                        instr_d = req_op;
                        state_d = ST_LOAD;
                    end else begin
                        // Illegal code never reaches the ALU; answer immediately.
                        result_d = '0;
                        wide_d   = 1'b0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                z_en    = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                result_d = z_lo_q;
                wide_d   = is_wide_op(op_q);
                err_d    = div_zero;
                hilo_en  = is_wide_op(op_q) && !div_zero;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            instr_q  <= '0;
            result_q <= '0;
            wide_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            wide_q   <= wide_d;
            err_q    <= err_d;
        end
    end

    reg32 #(.WIDTH(DATA_WIDTH)) u_y_reg (
        .clock(clock), .clear(clear), .enable(y_en), .d(req_a), .q(y_q)
    );

    reg32 #(.WIDTH(DATA_WIDTH)) u_b_reg (
        .clock(clock), .clear(clear), .enable(b_en), .d(req_b), .q(b_q)
    );

    reg32 #(.WIDTH(DATA_WIDTH)) u_z_hi_reg (
        .clock(clock), .clear(clear), .enable(z_en), .d(alu_Z_hi), .q(z_hi_q)
    );

    reg32 #(.WIDTH(DATA_WIDTH)) u_z_lo_reg (
        .clock(clock), .clear(clear), .enable(z_en), .d(alu_Z_lo), .q(z_lo_q)
    );

    reg32 #(.WIDTH(DATA_WIDTH)) u_hi_reg (
        .clock(clock), .clear(clear), .enable(hilo_en), .d(z_hi_q), .q(hi_out)
    );

    reg32 #(.WIDTH(DATA_WIDTH)) u_lo_reg (
        .clock(clock), .clear(clear), .enable(hilo_en), .d(z_lo_q), .q(lo_out)
    );

    assign req_ready       = (state_q == ST_IDLE);
    assign resp_valid      = (state_q == ST_RESP);
    assign alu_instruction = instr_q;
    assign alu_Y_in        = y_q;
    assign alu_B_in        = b_q;
    assign resp_result     = result_q;
    assign resp_wide       = wide_q;
    assign resp_err        = err_q;

endmodule
